ppi_group_a_port: RTL and testbench
===================================

# ppi_group_a_port

Port A data path and handshake engine of the 8255-style PPI, directly downstream of the chip control logic. Consumes its per-access selects (port A select, control-word select) together with one-cycle read and write strobes. Owns:
- the group A control-word fields;
- the port A latches;
- the mode 1 strobed handshake (STB/IBF/INTR on input, OBF/ACK/INTR on output).

Mode 2 is out of scope.

## Interface
Parameters:
- DW, 8, data bus and port width
- SYNC_STAGES, 2, synchronizer depth on stb_n/ack_n (minimum 2)

Ports:
- clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- wr_strobe  in  1  one-cycle pulse, CPU write completed (CS_n low)
- rd_strobe  in  1  one-cycle pulse, CPU read completed
- sel_a  in  1  port A addressed (A=00)
- sel_ctrl  in  1  control word addressed (A=11)
- din  in  DW  CPU write data
- pa_in  in  DW  port A pins, input direction
- stb_n  in  1  peripheral strobe, mode 1 input (PC4)
- ack_n  in  1  peripheral acknowledge, mode 1 output (PC6)
- dout  out  DW  port A read data to bus buffer
- pa_out  out  DW  port A output latch
- pa_oe  out  1  port A pin drive enable
- ibf  out  1  input buffer full (PC5)
- obf_n  out  1  output buffer full, active low (PC7)
- intr  out  1  interrupt request A (PC3)
- mode1  out  1  group A in mode 1 (PC3..PC7 owned by this block)
- dir_in  out  1  port A direction, 1 = input

## Operation
Control word write (sel_ctrl & wr_strobe):
- din[7]=1, din[6]=0: mode set.
  - mode1 <= din[5]; dir_in <= din[4].
  - Clears pa_out=0, ibf=0, obf_n=1, intr=0, inte_in=0, inte_out=0.
- din[7]=1, din[6]=1: mode 2 request; word ignored entirely.
- din[7]=0: port C bit set/reset.
  - Index din[3:1], value din[0].
  - Index 4 writes inte_in; index 6 writes inte_out.
  - All other indices ignored here.

Mode 0:
- Input: port A read returns the pa_in value registered on the cycle before rd_strobe.
- Output: port A write loads pa_out.
- ibf=0, obf_n=1, intr=0 held.

Mode 1 input:
- stb_n falling edge (post-sync) loads the input latch from pa_in and sets ibf.
- stb_n rising edge with ibf=1 and inte_in=1 sets intr.
- Port A read returns the latch and clears intr and ibf.
- Strobe while ibf=1 overwrites the latch; ibf stays 1.

Mode 1 output:
- Port A write loads pa_out, clears obf_n to 0 and clears intr.
- ack_n falling edge sets obf_n=1.
- ack_n rising edge with obf_n=1 and inte_out=1 sets intr.
- Write while obf_n=0 overwrites pa_out; obf_n stays 0.

Common rules:
- pa_oe = ~dir_in.
- Port A write while dir_in=1 is ignored.
- Port A read while dir_in=0 returns pa_out.
- dout holds its value between reads.

## Timing
Reset values:
- dout=0, pa_out=0, pa_oe=0, dir_in=1, mode1=0
- ibf=0, obf_n=1, intr=0
- inte_in=0, inte_out=0, input latch=0
- synchronizer flops=1

Latencies:
- Strobe register updates occur on the clk edge where the strobe is high; outputs are visible the next cycle.
- stb_n/ack_n edge to flag change = SYNC_STAGES+1 cycles (3 at default). pa_in is sampled on that same edge-detect cycle.
- Read data valid on dout the cycle after rd_strobe.

Simultaneous events:
- Read and strobe-fall in the same cycle: latch reloads, ibf stays 1, intr cleared.
- Strobe-rise and read in the same cycle: read wins, intr=0.
- Write and ack-fall in the same cycle: write wins, obf_n=0.
- Mode set coinciding with any handshake event: mode set wins.
- wr_strobe and rd_strobe together: treat as protocol error, no state change.

Reset:
- Reset mid-handshake returns all state to reset values on the next edge.
- Handshake inputs are ignored while Reset is high.
- Edge detectors re-arm from the idle-high state, so a stb_n already low after Reset deasserts produces no edge until it rises and falls again.

## Structure
- Shared package ppi_pkg holds:
  - CW_MODE_SET (bit 7), CW_DIR_A (bit 4), CW_MODE_A (bits 6:5);
  - PC_INTR_A=3, PC_STB_A=4, PC_IBF_A=5, PC_ACK_A=6, PC_OBF_A=7.
- Sub-module ppi_sync_edge: SYNC_STAGES-deep synchronizer with reset-to-1 and one-cycle fall/rise pulse outputs. Instantiated twice, for stb_n and ack_n.
- Remaining logic is a single clocked process plus read-mux.

## Test plan
- Reset, then read port A with pa_in=8'h5A -> dout=8'h5A, pa_oe=0, obf_n=1, intr=0.
- Control word 8'h80, then write 8'h3C to port A -> pa_out=8'h3C, pa_oe=1, ibf/intr stay 0.
- Control word 8'hB0, then bit-set 8'h09 (inte_in), pa_in=8'hA5, pulse stb_n low then high:
  - ibf=1 three cycles after the fall;
  - intr=1 after the rise;
  - read -> dout=8'hA5, ibf=0, intr=0.
- Control word 8'hA0, then bit-set 8'h0D (inte_out), write 8'h77 -> obf_n=0. Pulse ack_n -> obf_n=1 after the fall, intr=1 after the rise. Next write clears intr.
- Mode 1 input with ibf=1 and intr=1, then control word 8'h90 -> mode1=0, ibf=0, intr=0, inte_in=0.
- Assert Reset while obf_n=0 in mode 1 output -> next cycle obf_n=1, pa_out=0, dir_in=1, pa_oe=0. Control word 8'hC0 afterwards -> no state change.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared PPI definitions: control-word bit positions, port C bit indices
// and the control-word decode used by the group A port.
package ppi_pkg;

  localparam int unsigned CW_WIDTH    = 8;
  localparam int unsigned CW_MODE_SET = 7;
  localparam int unsigned CW_MODE_A   = 5;  // group A mode field occupies [6:5]
  localparam int unsigned CW_MODE_A_W = 2;
  localparam int unsigned CW_DIR_A    = 4;

  localparam int unsigned PC_INTR_A = 3;
  localparam int unsigned PC_STB_A  = 4;
  localparam int unsigned PC_IBF_A  = 5;
  localparam int unsigned PC_ACK_A  = 6;
  localparam int unsigned PC_OBF_A  = 7;

  typedef struct packed {
    logic       mode_set;  // mode 0/1 set; mode 2 requests never assert this
    logic       mode1;
    logic       dir_in;
    logic       bsr;       // port C bit set/reset
    logic [2:0] bit_idx;
    logic       bit_val;
  } cw_dec_t;

  function automatic cw_dec_t cw_decode(input logic [CW_WIDTH-1:0] w);
    cw_dec_t d;
    d.mode_set = w[CW_MODE_SET] & ~w[CW_MODE_A + CW_MODE_A_W - 1];
    d.mode1    = w[CW_MODE_A];
    d.dir_in   = w[CW_DIR_A];
    d.bsr      = ~w[CW_MODE_SET];
    d.bit_idx  = w[3:1];
    d.bit_val  = w[0];
    return d;
  endfunction

endpackage

// File: rtl/ppi_sync_edge.sv
// Reset-to-1 synchronizer with fall/rise pulses. Edges are only reported
// once a genuine high level has passed through the chain after reset.
module ppi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic Reset,
  input  logic d,
  output logic fall_c,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] vld_q;
  logic              prev_q;
  logic              armed_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      sync_q  <= '1;
      vld_q   <= '0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      vld_q  <= {vld_q[STAGES-2:0], 1'b1};
      prev_q <= sync_q[STAGES-1];
      if (vld_q[STAGES-1] && sync_q[STAGES-1]) armed_q <= 1'b1;
    end
  end

  assign fall_c = armed_q & prev_q & ~sync_q[STAGES-1];
  assign rise_c = armed_q & ~prev_q & sync_q[STAGES-1];

endmodule

// File: rtl/ppi_group_a_port.sv
// 8255-style group A: control-word fields, port A latches and the mode 1
// STB/IBF/INTR (input) and OBF/ACK/INTR (output) handshakes.
module ppi_group_a_port
  import ppi_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          wr_strobe,
  input  logic          rd_strobe,
  input  logic          sel_a,
  input  logic          sel_ctrl,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] pa_in,
  input  logic          stb_n,
  input  logic          ack_n,
  output logic [DW-1:0] dout,
  output logic [DW-1:0] pa_out,
  output logic          pa_oe,
  output logic          ibf,
  output logic          obf_n,
  output logic          intr,
  output logic          mode1,
  output logic          dir_in
);

  logic          stb_fall_c, stb_rise_c, ack_fall_c, ack_rise_c;
  logic          bus_ok_c, wr_a_c, rd_a_c, wr_ctrl_c, hs_in_c, hs_out_c;
  logic [DW-1:0] rd_data_c;
  logic [DW-1:0] pa_in_q;
  logic [DW-1:0] latch_q;
  logic          inte_in, inte_out;
  cw_dec_t       cw_c;

  ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clk    (clk),
    .Reset  (Reset),
    .d      (stb_n),
    .fall_c (stb_fall_c),
    .rise_c (stb_rise_c)
  );

  ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk    (clk),
    .Reset  (Reset),
    .d      (ack_n),
    .fall_c (ack_fall_c),
    .rise_c (ack_rise_c)
  );

  // Simultaneous read and write strobes are a bus protocol error and are dropped.
  assign bus_ok_c  = ~(wr_strobe & rd_strobe);
  assign wr_a_c    = wr_strobe & sel_a & bus_ok_c;
  assign rd_a_c    = rd_strobe & sel_a & bus_ok_c;
  assign wr_ctrl_c = wr_strobe & sel_ctrl & bus_ok_c;
  assign hs_in_c   = mode1 & dir_in;
  assign hs_out_c  = mode1 & ~dir_in;
  assign cw_c      = cw_decode(din[CW_WIDTH-1:0]);

  always_comb begin
    rd_data_c = pa_out;
    if (dir_in) rd_data_c = mode1 ? latch_q : pa_in_q;
  end

  // Later assignments take priority: mode set overrides any handshake event.
  always_ff @(posedge clk) begin
    if (Reset) begin
      dout     <= '0;
      pa_out   <= '0;
      pa_oe    <= 1'b0;
      dir_in   <= 1'b1;
      mode1    <= 1'b0;
      ibf      <= 1'b0;
      obf_n    <= 1'b1;
      intr     <= 1'b0;
      inte_in  <= 1'b0;
      inte_out <= 1'b0;
      latch_q  <= '0;
      pa_in_q  <= '0;
    end else begin
      pa_in_q <= pa_in;

      if (rd_a_c) dout <= rd_data_c;
      if (wr_a_c && !dir_in) pa_out <= din;

      if (hs_in_c) begin
        if (rd_a_c) begin
          ibf  <= 1'b0;
          intr <= 1'b0;
        end else if (stb_rise_c && ibf && inte_in) begin
          intr <= 1'b1;
        end
        if (stb_fall_c) begin
          latch_q <= pa_in;
          ibf     <= 1'b1;
        end
      end

      if (hs_out_c) begin
        if (wr_a_c) begin
          obf_n <= 1'b0;
          intr  <= 1'b0;
        end else begin
          if (ack_fall_c) obf_n <= 1'b1;
          if (ack_rise_c && obf_n && inte_out) intr <= 1'b1;
        end
      end

      if (wr_ctrl_c && cw_c.bsr) begin
        if (cw_c.bit_idx == 3'(PC_STB_A)) inte_in  <= cw_c.bit_val;
        if (cw_c.bit_idx == 3'(PC_ACK_A)) inte_out <= cw_c.bit_val;
      end

      if (wr_ctrl_c && cw_c.mode_set) begin
        mode1    <= cw_c.mode1;
        dir_in   <= cw_c.dir_in;
        pa_oe    <= ~cw_c.dir_in;
        pa_out   <= '0;
        ibf      <= 1'b0;
        obf_n    <= 1'b1;
        intr     <= 1'b0;
        inte_in  <= 1'b0;
        inte_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppi_group_a_port.sv
// Randomized bench for ppi_group_a_port against a transaction-level model.
module tb_ppi_group_a_port;

  logic       clk = 1'b0;
  logic       Reset, wr_strobe, rd_strobe, sel_a, sel_ctrl, stb_n, ack_n;
  logic [7:0] din, pa_in;
  logic [7:0] dout, pa_out;
  logic       pa_oe, ibf, obf_n, intr, mode1, dir_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic       m_mode1, m_dir, m_ibf, m_obf_n, m_intr, m_inte_in, m_inte_out;
  logic [7:0] m_pa_out, m_latch, m_dout, m_pins;

  ppi_group_a_port #(.DW(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .Reset(Reset), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
    .sel_a(sel_a), .sel_ctrl(sel_ctrl), .din(din), .pa_in(pa_in),
    .stb_n(stb_n), .ack_n(ack_n), .dout(dout), .pa_out(pa_out), .pa_oe(pa_oe),
    .ibf(ibf), .obf_n(obf_n), .intr(intr), .mode1(mode1), .dir_in(dir_in)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode1 = 0; m_dir = 1; m_ibf = 0; m_obf_n = 1; m_intr = 0;
    m_inte_in = 0; m_inte_out = 0; m_pa_out = 0; m_latch = 0; m_dout = 0;
  endtask

  task automatic model_cw(input logic [7:0] w);
    if (w[7] && !w[6]) begin
      m_mode1 = w[5]; m_dir = w[4]; m_pa_out = 0; m_ibf = 0; m_obf_n = 1;
      m_intr = 0; m_inte_in = 0; m_inte_out = 0;
    end else if (!w[7]) begin
      if (w[3:1] == 3'd4) m_inte_in  = w[0];
      if (w[3:1] == 3'd6) m_inte_out = w[0];
    end
  endtask

  // One bus access, issued at a falling clock edge; model follows the access.
  task automatic cpu(input logic is_wr, input logic is_ctrl, input logic [7:0] d);
    sel_a = !is_ctrl; sel_ctrl = is_ctrl; wr_strobe = is_wr; rd_strobe = !is_wr; din = d;
    @(negedge clk);
    sel_a = 0; sel_ctrl = 0; wr_strobe = 0; rd_strobe = 0;
    if (is_wr && is_ctrl) model_cw(d);
    else if (is_wr && !m_dir) begin
      m_pa_out = d;
      if (m_mode1) begin m_obf_n = 0; m_intr = 0; end
    end else if (!is_wr && !is_ctrl) begin
      m_dout = !m_dir ? m_pa_out : (m_mode1 ? m_latch : m_pins);
      if (m_mode1 && m_dir) begin m_ibf = 0; m_intr = 0; end
    end
  endtask

  task automatic set_pins(input logic [7:0] v);
    pa_in = v;
    @(negedge clk);
    m_pins = v;
  endtask

  // Drive a strobe level and wait out the synchronizer latency.
  task automatic stb_edge(input logic lvl);
    stb_n = lvl;
    repeat (3) @(negedge clk);
    if (m_mode1 && m_dir) begin
      if (!lvl) begin m_latch = pa_in; m_ibf = 1; end
      else if (m_ibf && m_inte_in) m_intr = 1;
    end
  endtask

  task automatic ack_edge(input logic lvl);
    ack_n = lvl;
    repeat (3) @(negedge clk);
    if (m_mode1 && !m_dir) begin
      if (!lvl) m_obf_n = 1;
      else if (m_obf_n && m_inte_out) m_intr = 1;
    end
  endtask

  task automatic test_reset();
    Reset = 1; wr_strobe = 0; rd_strobe = 0; sel_a = 0; sel_ctrl = 0;
    din = 0; pa_in = 0; stb_n = 1; ack_n = 1; m_pins = 0;
    repeat (3) @(negedge clk);
    Reset = 0;
    model_reset();
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", dout); end
    n_tests++; if (pa_out !== 8'h00) begin n_fail++; $display("FAIL reset_pa_out got %h exp 00", pa_out); end
    n_tests++; if (pa_oe !== 1'b0) begin n_fail++; $display("FAIL reset_pa_oe got %b exp 0", pa_oe); end
    n_tests++; if (dir_in !== 1'b1) begin n_fail++; $display("FAIL reset_dir_in got %b exp 1", dir_in); end
    n_tests++; if (mode1 !== 1'b0) begin n_fail++; $display("FAIL reset_mode1 got %b exp 0", mode1); end
    n_tests++; if ({ibf, obf_n, intr} !== 3'b010) begin n_fail++; $display("FAIL reset_flags got ibf/obf_n/intr %b exp 010", {ibf, obf_n, intr}); end
  endtask

  task automatic test_mode0_input();
    logic [7:0] v;
    set_pins(8'h5A);
    cpu(0, 0, 0);
    n_tests++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL m0in_read got %h exp 5a", dout); end
    n_tests++; if ({pa_oe, obf_n, intr} !== 3'b010) begin n_fail++; $display("FAIL m0in_pins got oe/obf_n/intr %b exp 010", {pa_oe, obf_n, intr}); end
    for (int i = 0; i < 4; i++) begin
      set_pins(8'($urandom));
      cpu(0, 0, 0);
      n_tests++; if (dout !== m_dout) begin n_fail++; $display("FAIL m0in_rand got %h exp %h", dout, m_dout); end
    end
    // Pins changing in the read cycle are not yet visible.
    v = m_pins;
    pa_in = ~v;
    cpu(0, 0, 0);
    n_tests++; if (dout !== v) begin n_fail++; $display("FAIL m0in_prev_cycle got %h exp %h", dout, v); end
    @(negedge clk); m_pins = pa_in;
    cpu(1, 0, 8'($urandom));
    n_tests++; if (pa_out !== m_pa_out) begin n_fail++; $display("FAIL m0in_write_ignored got %h exp %h", pa_out, m_pa_out); end
  endtask

  task automatic test_mode0_output();
    cpu(1, 1, 8'h80);
    n_tests++; if ({dir_in, pa_oe, mode1} !== 3'b010) begin n_fail++; $display("FAIL m0out_cfg got dir/oe/mode1 %b exp 010", {dir_in, pa_oe, mode1}); end
    cpu(1, 0, 8'h3C);
    n_tests++; if (pa_out !== 8'h3C) begin n_fail++; $display("FAIL m0out_write got %h exp 3c", pa_out); end
    for (int i = 0; i < 4; i++) begin
      cpu(1, 0, 8'($urandom));
      cpu(0, 0, 0);
      n_tests++; if (pa_out !== m_pa_out) begin n_fail++; $display("FAIL m0out_pa_out got %h exp %h", pa_out, m_pa_out); end
      n_tests++; if (dout !== m_dout) begin n_fail++; $display("FAIL m0out_readback got %h exp %h", dout, m_dout); end
    end
    n_tests++; if ({ibf, obf_n, intr} !== 3'b010) begin n_fail++; $display("FAIL m0out_flags got %b exp 010", {ibf, obf_n, intr}); end
  endtask

  task automatic test_mode1_input();
    cpu(1, 1, 8'hB0);
    cpu(1, 1, 8'h09);
    n_tests++; if ({mode1, dir_in, pa_oe} !== 3'b110) begin n_fail++; $display("FAIL m1in_cfg got %b exp 110", {mode1, dir_in, pa_oe}); end
    pa_in = 8'hA5;
    stb_n = 0;
    repeat (2) @(negedge clk);
    n_tests++; if (ibf !== 1'b0) begin n_fail++; $display("FAIL m1in_ibf_early got %b exp 0", ibf); end
    @(negedge clk);
    m_latch = 8'hA5; m_ibf = 1;
    n_tests++; if (ibf !== 1'b1) begin n_fail++; $display("FAIL m1in_ibf_3cyc got %b exp 1", ibf); end
    stb_edge(1);
    n_tests++; if (intr !== 1'b1) begin n_fail++; $display("FAIL m1in_intr got %b exp 1", intr); end
    cpu(0, 0, 0);
    n_tests++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL m1in_read got %h exp a5", dout); end
    n_tests++; if ({ibf, intr} !== 2'b00) begin n_fail++; $display("FAIL m1in_read_clr got %b exp 00", {ibf, intr}); end
    for (int i = 0; i < 6; i++) begin
      cpu(1, 1, {4'b0000, 3'd4, 1'($urandom)});
      pa_in = 8'($urandom);
      stb_edge(0);
      if ($urandom_range(0, 1) == 1) begin
        stb_edge(1);
        pa_in = 8'($urandom);
        stb_edge(0);
      end
      stb_edge(1);
      n_tests++; if ({ibf, intr} !== {m_ibf, m_intr}) begin n_fail++; $display("FAIL m1in_rand_flags got %b exp %b", {ibf, intr}, {m_ibf, m_intr}); end
      cpu(0, 0, 0);
      n_tests++; if (dout !== m_dout) begin n_fail++; $display("FAIL m1in_rand_read got %h exp %h", dout, m_dout); end
      n_tests++; if ({ibf, intr} !== 2'b00) begin n_fail++; $display("FAIL m1in_rand_clr got %b exp 00", {ibf, intr}); end
    end
  endtask

  task automatic test_mode1_output();
    cpu(1, 1, 8'hA0);
    cpu(1, 1, 8'h0D);
    cpu(1, 0, 8'h77);
    n_tests++; if ({obf_n, pa_out, pa_oe} !== {1'b0, 8'h77, 1'b1}) begin n_fail++; $display("FAIL m1out_write got obf_n=%b pa_out=%h oe=%b exp 0 77 1", obf_n, pa_out, pa_oe); end
    ack_edge(0);
    n_tests++; if (obf_n !== 1'b1) begin n_fail++; $display("FAIL m1out_ack_fall got %b exp 1", obf_n); end
    ack_edge(1);
    n_tests++; if (intr !== 1'b1) begin n_fail++; $display("FAIL m1out_ack_rise got %b exp 1", intr); end
    cpu(1, 0, 8'($urandom));
    n_tests++; if ({intr, obf_n} !== 2'b00) begin n_fail++; $display("FAIL m1out_write_clr got %b exp 00", {intr, obf_n}); end
    for (int i = 0; i < 6; i++) begin
      cpu(1, 1, {4'b0000, 3'd6, 1'($urandom)});
      cpu(1, 0, 8'($urandom));
      if ($urandom_range(0, 1) == 1) cpu(1, 0, 8'($urandom));
      n_tests++; if ({obf_n, pa_out} !== {m_obf_n, m_pa_out}) begin n_fail++; $display("FAIL m1out_rand_write got %b %h exp %b %h", obf_n, pa_out, m_obf_n, m_pa_out); end
      ack_edge(0);
      ack_edge(1);
      n_tests++; if ({obf_n, intr} !== {m_obf_n, m_intr}) begin n_fail++; $display("FAIL m1out_rand_ack got %b exp %b", {obf_n, intr}, {m_obf_n, m_intr}); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] old;
    cpu(1, 1, 8'hB0);
    cpu(1, 1, 8'h09);
    pa_in = 8'($urandom);
    stb_edge(0);
    stb_edge(1);
    old = m_latch;
    // Strobe fall lands in the same cycle as the read.
    pa_in = 8'($urandom);
    stb_n = 0;
    repeat (2) @(negedge clk);
    cpu(0, 0, 0);
    m_latch = pa_in; m_ibf = 1;
    n_tests++; if (dout !== old) begin n_fail++; $display("FAIL sim_rd_fall_dout got %h exp %h", dout, old); end
    n_tests++; if ({ibf, intr} !== 2'b10) begin n_fail++; $display("FAIL sim_rd_fall_flags got %b exp 10", {ibf, intr}); end
    stb_edge(1);
    cpu(0, 0, 0);
    n_tests++; if (dout !== m_dout) begin n_fail++; $display("FAIL sim_rd_fall_reload got %h exp %h", dout, m_dout); end
    // Read and write strobes together change nothing.
    cpu(1, 1, 8'h80);
    cpu(1, 0, 8'($urandom));
    sel_a = 1; wr_strobe = 1; rd_strobe = 1; din = ~m_pa_out;
    @(negedge clk);
    sel_a = 0; wr_strobe = 0; rd_strobe = 0;
    n_tests++; if ({pa_out, dout} !== {m_pa_out, m_dout}) begin n_fail++; $display("FAIL sim_wr_rd got %h %h exp %h %h", pa_out, dout, m_pa_out, m_dout); end
  endtask

  task automatic test_mode_set_clear();
    cpu(1, 1, 8'hB0);
    cpu(1, 1, 8'h09);
    pa_in = 8'($urandom);
    stb_edge(0);
    stb_edge(1);
    n_tests++; if ({ibf, intr} !== 2'b11) begin n_fail++; $display("FAIL mset_pre got %b exp 11", {ibf, intr}); end
    cpu(1, 1, 8'h90);
    n_tests++; if ({mode1, dir_in, ibf, intr} !== 4'b0100) begin n_fail++; $display("FAIL mset_clear got %b exp 0100", {mode1, dir_in, ibf, intr}); end
  endtask

  task automatic test_reset_mid();
    cpu(1, 1, 8'hA0);
    cpu(1, 0, 8'($urandom_range(1, 255)));
    n_tests++; if (obf_n !== 1'b0) begin n_fail++; $display("FAIL rmid_pre got %b exp 0", obf_n); end
    Reset = 1;
    @(negedge clk);
    Reset = 0;
    model_reset();
    n_tests++; if ({obf_n, dir_in, pa_oe, mode1, intr} !== 5'b11000 || pa_out !== 8'h00) begin n_fail++; $display("FAIL rmid_state got %b pa_out=%h exp 11000 00", {obf_n, dir_in, pa_oe, mode1, intr}, pa_out); end
    cpu(1, 1, 8'hC0);
    n_tests++; if ({dir_in, mode1, pa_oe} !== 3'b100) begin n_fail++; $display("FAIL mode2_ignored got %b exp 100", {dir_in, mode1, pa_oe}); end
    cpu(1, 1, 8'h80);
    cpu(1, 0, 8'($urandom));
    cpu(1, 1, 8'hC0);
    n_tests++; if ({dir_in, pa_out} !== {m_dir, m_pa_out}) begin n_fail++; $display("FAIL mode2_keep got %b %h exp %b %h", dir_in, pa_out, m_dir, m_pa_out); end
  endtask

  task automatic test_rearm();
    Reset = 1; stb_n = 0;
    repeat (3) @(negedge clk);
    // Leave reset and select mode 1 input while the strobe is still low.
    Reset = 0; sel_ctrl = 1; wr_strobe = 1; din = 8'hB0;
    @(negedge clk);
    sel_ctrl = 0; wr_strobe = 0;
    model_reset(); model_cw(8'hB0);
    repeat (6) @(negedge clk);
    n_tests++; if (ibf !== 1'b0) begin n_fail++; $display("FAIL rearm_no_edge got %b exp 0", ibf); end
    stb_edge(1);
    pa_in = 8'($urandom);
    stb_edge(0);
    n_tests++; if (ibf !== m_ibf) begin n_fail++; $display("FAIL rearm_edge got %b exp %b", ibf, m_ibf); end
    cpu(0, 0, 0);
    n_tests++; if (dout !== m_dout) begin n_fail++; $display("FAIL rearm_read got %h exp %h", dout, m_dout); end
    stb_edge(1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mode0_input();
    test_mode0_output();
    test_mode1_input();
    test_mode1_output();
    test_simultaneous();
    test_mode_set_clear();
    test_reset_mid();
    test_rearm();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
